// File: rtl/pc_lut_seq.sv
// pc_lut_seq: sequential population counter.
//
// Accepts one WIDTH-bit word and counts its one bits (mode=0) or its zero
// bits (mode=1). The operand is processed one byte per clock through a
// combinational 8-bit popcount, so a result appears NB = WIDTH/8 cycles
// after the input handshake. Only one word is in flight at a time.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   data/mode presented
//   in_ready   high only while idle (and throughout reset)
//   data       word to be counted
//   mode       0 = count ones, 1 = count zeros
//   out_valid  count is valid (registered, independent of out_ready)
//   out_ready  consumer accepts count
//   count      population count, CW = $clog2(WIDTH+1) bits
module pc_lut_seq #(
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           data,
    input  logic                       mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(WIDTH+1)-1:0] count
);

    localparam int NB = WIDTH / 8;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Popcount of one byte, values 0..8, purely combinational.
    function automatic logic [3:0] pop8(input logic [7:0] b);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, b[i]};
        end
        return n;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] opnd_q,  opnd_d;
    logic [CW-1:0]    acc_q,   acc_d;
    logic [IW-1:0]    idx_q,   idx_d;
    logic [CW-1:0]    count_q, count_d;

    logic [3:0]       byte_pc;
    logic [CW-1:0]    sum;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign count     = count_q;

    // The operand register shifts right one byte per RUN cycle, so the byte
    // selected by idx_q always sits in the low 8 bits.
    assign byte_pc = pop8(opnd_q[7:0]);

    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        count_d = count_q;
        sum     = acc_q + CW'(byte_pc);

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    opnd_d  = mode ? ~data : data;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                opnd_d = opnd_q >> 8;
                acc_d  = sum;
                idx_d  = idx_q + IW'(1);
                if (idx_q == LAST_IDX) begin
                    count_d = sum;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opnd_q  <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            count_q <= count_d;
        end
    end

endmodule

// File: doc/pc_lut_seq.md
PC_LUT_SEQ -- requirements
Module: pc_lut_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32: input word width in bits; legal values are multiples of 8 from 8 to 256.
REQ-002 SHALL have localparam NB = WIDTH/8: the number of bytes processed per word.
REQ-003 SHALL have localparam CW = $clog2(WIDTH+1): the width of the result.
REQ-004 clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  data and mode are presented.
REQ-007 in_ready  output  1  block can accept a word.
REQ-008 data  input  WIDTH  word to be counted.
REQ-009 mode  input  1  0 = count ones; 1 = count zeros.
REQ-010 out_valid  output  1  count is valid.
REQ-011 out_ready  input  1  consumer accepts count.
REQ-012 count  output  CW  population count result.

Function
REQ-013 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE, and SHALL drive out_valid=1 only in DONE.
REQ-015 In IDLE, an input handshake is in_valid & in_ready; on it the block SHALL, at the same edge:
- capture the operand (data if mode=0, ~data if mode=1) into an internal shift register;
- clear the accumulator;
- clear the byte index;
- enter RUN.
REQ-016 In IDLE without in_valid, all state SHALL hold.
REQ-017 In RUN, each cycle the block SHALL add the 8-bit popcount of the operand byte selected by the index to the accumulator, starting at byte 0 (LSB) and advancing one byte per cycle.
REQ-018 The per-byte popcount SHALL be an internal combinational 256-entry table or equivalent, producing values 0..8 with no extra cycle of latency.
REQ-019 On the cycle that processes byte NB-1, the FSM SHALL move to DONE and load count with the final sum.
REQ-020 out_valid SHALL rise exactly NB cycles after the input-handshake edge.
REQ-021 Data, mode and in_valid changes SHALL be ignored outside IDLE; the captured operand alone determines the result.
REQ-022 In DONE, count SHALL hold stable until out_valid & out_ready; on that edge the FSM SHALL return to IDLE.
REQ-023 out_valid SHALL NOT depend combinationally on out_ready.
REQ-024 A new word SHALL be accepted no earlier than the cycle after the output handshake (no overlap). Throughput is therefore one word per NB+2 cycles when out_ready=1.
REQ-025 Accumulator arithmetic SHALL be CW bits wide, unsigned, and SHALL never overflow; the maximum result is WIDTH.
REQ-026 When WIDTH=8 (NB=1), RUN SHALL last exactly one cycle.
REQ-027 count SHALL retain its last value in IDLE and RUN, and SHALL be meaningful only while out_valid=1.

Reset
REQ-028 When rst_n=0, the block SHALL asynchronously force:
- FSM to IDLE;
- count=0, accumulator=0, byte index=0, operand register=0;
- out_valid=0.
REQ-029 While rst_n=0, in_ready SHALL be 1.
REQ-030 Reset asserted during RUN or DONE SHALL abort the operation, and no out_valid SHALL be produced for the aborted word.
REQ-031 After rst_n deasserts, the first rising edge SHALL be able to accept a word.

Verification
REQ-032 WIDTH=32, data=32'hFFFFFFFF, mode=0, out_ready=1 -> out_valid rises 4 cycles after accept, count=32, in_ready=1 the following cycle.
REQ-033 WIDTH=32, data=32'h00000000, mode=1 -> count=32; then data=32'h80000001, mode=0 -> count=2; then data=32'h0F0F00F0, mode=1 -> count=20.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles in DONE, and toggle data/in_valid throughout -> count, out_valid=1 and in_ready=0 stay stable; on out_ready=1, exactly one output handshake occurs.
REQ-035 Reset mid-operation: drop rst_n two cycles into RUN -> out_valid=0, count=0 and in_ready=1 immediately (asynchronously); the next word, 32'h00000003, gives count=2.
REQ-036 Parameter sweep:
- WIDTH=8, data=8'hA5, mode=0 -> count=4, one cycle after accept.
- WIDTH=256, all ones -> count=256, 32 cycles after accept.
- 1000 random words per width checked against a reference popcount model.
